bits_to_words: RTL and testbench

Parametrised bit/chunk-to-word packer for the OFDM receive datapath. It accepts `IN_W`-bit chunks from the descrambler/decoder on a strobe and assembles them into `OUT_W`-bit words. It supports selectable bit order and end-of-packet flush of a zero-padded partial word. It replaces the fixed 1-bit-to-8-bit packer and feeds the byte/word consumers (CRC, DMA framing).

---
 rtl/openofdm_rx_pkg.sv | 9 +
 rtl/bits_to_words_chunk_place.sv | 24 ++
 rtl/bits_to_words.sv | 106 ++++++++++
 tb/tb_bits_to_words.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/openofdm_rx_pkg.sv
// openofdm_rx_pkg: shared constants and helpers for the OFDM receive datapath.
//   BTW_MAX_OUT_W : widest word bits_to_words may be built for
//   valid_bits_w  : width of a bit-count field able to hold 0..out_w
package openofdm_rx_pkg;
    localparam int BTW_MAX_OUT_W = 64;
    function automatic int valid_bits_w(input int out_w);
        return $clog2(out_w) + 1;
    endfunction
endpackage

// File: rtl/bits_to_words_chunk_place.sv
// chunk_place: positions one IN_W-bit chunk inside an OUT_W-bit word.
//   data_in  in  IN_W     chunk to place
//   fill     in  FILL_W   bits already in the word (multiple of IN_W)
//   ord      in  1        0: fill upward from bit 0, 1: fill downward from the MSB
//   ins_mask out OUT_W    ones over the chunk's target bits
//   ins_data out OUT_W    chunk shifted to its target bits, zero elsewhere
module chunk_place #(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 8,
    parameter int FILL_W = $clog2(OUT_W)
) (
    input  logic [IN_W-1:0]   data_in,
    input  logic [FILL_W-1:0] fill,
    input  logic              ord,
    output logic [OUT_W-1:0]  ins_mask,
    output logic [OUT_W-1:0]  ins_data
);
    localparam logic [FILL_W-1:0] TOP = FILL_W'(OUT_W - IN_W);
    logic [FILL_W-1:0] pos;
    // MSB-first mirrors the chunk slot, not the bits inside the chunk
    assign pos      = ord ? TOP - fill : fill;
    assign ins_mask = OUT_W'({IN_W{1'b1}}) << pos;
    assign ins_data = OUT_W'(data_in) << pos;
endmodule

// File: rtl/bits_to_words.sv
// bits_to_words: packs IN_W-bit chunks into OUT_W-bit words with bit-order select and end-of-packet flush.
//   clock, reset_n       clock (rising) and asynchronous active-low reset
//   enable, clear        strobe qualifier; synchronous flush dropping any partial word
//   msb_first            bit order, sampled when a word starts
//   data_in, input_strobe, last   input chunk, its valid, end-of-packet marker
//   word_out, output_strobe, word_last, valid_bits   emitted word and its attributes
//   word_count           words in current packet; counts only with BITS_TO_WORDS_WORD_CNT_EN defined, else 0
module bits_to_words
    import openofdm_rx_pkg::*;
#(
    parameter int IN_W  = 1,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           clear,
    input  logic                           msb_first,
    input  logic [IN_W-1:0]                data_in,
    input  logic                           input_strobe,
    input  logic                           last,
    output logic [OUT_W-1:0]               word_out,
    output logic                           output_strobe,
    output logic                           word_last,
    output logic [valid_bits_w(OUT_W)-1:0] valid_bits,
    output logic [CNT_W-1:0]               word_count
);
    localparam int FILL_W = $clog2(OUT_W);
    localparam int VBW    = valid_bits_w(OUT_W);
    localparam logic [FILL_W-1:0] TOP = FILL_W'(OUT_W - IN_W);

    if ((IN_W & (IN_W - 1)) != 0 || (OUT_W & (OUT_W - 1)) != 0 || OUT_W % IN_W != 0 ||
        OUT_W < 8 || OUT_W > BTW_MAX_OUT_W) begin : g_bad_params
        $error("bits_to_words: illegal IN_W/OUT_W combination");
    end

    logic [OUT_W-1:0]  acc_q, acc_d, word_q, ins_mask, ins_data;
    logic [FILL_W-1:0] fill_q;
    logic [VBW-1:0]    vb_q;
    logic              ord_q, strobe_q, last_q;
    logic              accept, complete, emit, ord_eff;

    assign accept   = enable & input_strobe & ~clear;
    // a fresh word takes the current order select; a word in progress keeps its own
    assign ord_eff  = (fill_q == '0) ? msb_first : ord_q;
    assign complete = fill_q == TOP;
    assign emit     = accept & (complete | last);
    assign acc_d    = (acc_q & ~ins_mask) | ins_data;

    chunk_place #(.IN_W(IN_W), .OUT_W(OUT_W), .FILL_W(FILL_W)) u_place (
        .data_in (data_in),
        .fill    (fill_q),
        .ord     (ord_eff),
        .ins_mask(ins_mask),
        .ins_data(ins_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            fill_q   <= '0;
            ord_q    <= 1'b0;
            word_q   <= '0;
            strobe_q <= 1'b0;
            last_q   <= 1'b0;
            vb_q     <= '0;
        end else begin
            strobe_q <= emit;
            if (clear) begin
                acc_q  <= '0;
                fill_q <= '0;
            end else if (accept) begin
                ord_q  <= ord_eff;
                acc_q  <= emit ? '0 : acc_d;
                fill_q <= emit ? '0 : fill_q + FILL_W'(IN_W);
            end
            // unfilled positions are already zero, so a flush needs no extra padding
            if (emit) begin
                word_q <= acc_d;
                last_q <= last;
                vb_q   <= VBW'(fill_q) + VBW'(IN_W);
            end
        end
    end

    assign word_out      = word_q;
    assign output_strobe = strobe_q;
    assign word_last     = last_q;
    assign valid_bits    = vb_q;

`ifdef BITS_TO_WORDS_WORD_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_base;
    // the count restarts the cycle after a packet's final word has been presented
    assign cnt_base = (strobe_q & last_q) ? '0 : cnt_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (emit) cnt_q <= (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        else cnt_q <= cnt_base;
    end
    assign word_count = cnt_q;
`else
    assign word_count = '0;
`endif
endmodule

// File: tb/tb_bits_to_words.sv
// tb_bits_to_words: drives a 1->8 and a 2->16 packer in lockstep and checks both against a chunk-list model.
module tb_bits_to_words;
    logic clock = 1'b0;
    logic reset_n, enable, clear, msb_first, stb, lst, d1;
    logic [1:0] d2;
    logic [7:0] w1;
    logic [15:0] w2, c1, c2;
    logic s1, l1, s2, l2;
    logic [3:0] vb1;
    logic [4:0] vb2;
    logic [29:0] g1;
    logic [38:0] g2;
    int iw[2] = '{1, 2};
    int ow[2] = '{8, 16};
    int k[2], evb[2], ec[2];
    longint acc[2], ew[2];
    bit ord[2], es[2], el[2];
    int n_cmp = 0, n_fail = 0;

    always #5 clock = ~clock;

    bits_to_words #(.IN_W(1), .OUT_W(8)) u1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .msb_first(msb_first),
        .data_in(d1), .input_strobe(stb), .last(lst), .word_out(w1), .output_strobe(s1),
        .word_last(l1), .valid_bits(vb1), .word_count(c1));
    bits_to_words #(.IN_W(2), .OUT_W(16)) u2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .msb_first(msb_first),
        .data_in(d2), .input_strobe(stb), .last(lst), .word_out(w2), .output_strobe(s2),
        .word_last(l2), .valid_bits(vb2), .word_count(c2));

    assign g1 = {s1, l1, vb1, w1, c1};
    assign g2 = {s2, l2, vb2, w2, c2};

    function automatic int xc(input int m);
`ifdef BITS_TO_WORDS_WORD_CNT_EN
        return ec[m];
`else
        return 0 * m;
`endif
    endfunction

    function automatic logic [29:0] exp1();
        return {es[0], el[0], 4'(evb[0]), 8'(ew[0]), 16'(xc(0))};
    endfunction

    function automatic logic [38:0] exp2();
        return {es[1], el[1], 5'(evb[1]), 16'(ew[1]), 16'(xc(1))};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            k[m] = 0; acc[m] = 0; ord[m] = 0; es[m] = 0; el[m] = 0; ew[m] = 0; evb[m] = 0; ec[m] = 0;
        end
    endtask

    // word = chunks laid out by index: slot k*IN_W from the bottom, or from the top when MSB-first
    task automatic model(input int m, input int d);
        int c;
        c = (es[m] && el[m]) ? 0 : ec[m];
        es[m] = 0;
        if (clear) begin
            k[m] = 0; acc[m] = 0; c = 0;
        end else if (enable && stb) begin
            if (k[m] == 0) ord[m] = msb_first;
            acc[m] |= longint'(d) << (ord[m] ? ow[m] - (k[m] + 1) * iw[m] : k[m] * iw[m]);
            k[m]++;
            if (k[m] * iw[m] == ow[m] || lst) begin
                ew[m] = acc[m]; evb[m] = k[m] * iw[m]; el[m] = lst; es[m] = 1;
                c = (c == 65535) ? c : c + 1;
                k[m] = 0; acc[m] = 0;
            end
        end
        ec[m] = c;
    endtask

    task automatic step(input bit en, input bit clr, input bit msb, input bit b1, input logic [1:0] b2,
                        input bit st, input bit ls);
        enable = en; clear = clr; msb_first = msb; d1 = b1; d2 = b2; stb = st; lst = ls;
        @(posedge clock);
        model(0, int'(b1));
        model(1, int'(b2));
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 0; clear = 0; msb_first = 0; d1 = 0; d2 = 0; stb = 0; lst = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (g1 !== '0) begin n_fail++; $display("FAIL reset_u1 got %h exp 0", g1); end
        n_cmp++; if (g2 !== '0) begin n_fail++; $display("FAIL reset_u2 got %h exp 0", g2); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_lsb_byte();
        bit b[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, b[i], 2'($urandom), 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL lsb_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL lsb_u2 got %h exp %h", g2, exp2()); end
            n_cmp++; if (s1 !== (i == 7)) begin n_fail++; $display("FAIL lsb_strobe got %b exp %b", s1, i == 7); end
        end
        n_cmp++;
        if ({w1, vb1, l1} !== {8'h4D, 4'd8, 1'b0}) begin
            n_fail++; $display("FAIL lsb_word got %h/%0d/%b exp 4d/8/0", w1, vb1, l1);
        end
    endtask

    task automatic test_msb_chunks();
        logic [1:0] ch[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 1'($urandom), ch[i % 4], 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL msb_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL msb_u2 got %h exp %h", g2, exp2()); end
            if (i % 8 == 7) begin
                n_cmp++;
                if ({s2, w2} !== {1'b1, 16'hC9C9}) begin
                    n_fail++; $display("FAIL msb_word got %b/%h exp 1/c9c9", s2, w2);
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 2'b01, 1, i == 2);
        n_cmp++;
        if ({s1, w1, vb1, l1} !== {1'b1, 8'h07, 4'd3, 1'b1}) begin
            n_fail++; $display("FAIL flush_word got %b/%h/%0d/%b exp 1/07/3/1", s1, w1, vb1, l1);
        end
        n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL flush_u2 got %h exp %h", g2, exp2()); end
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1'($urandom), 2'($urandom), 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL after_flush_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL after_flush_u2 got %h exp %h", g2, exp2()); end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 2'b11, 1, 0);
        step(1, 1, 0, 1, 2'b11, 1, 0);
        n_cmp++; if ({s1, s2} !== 2'b00) begin n_fail++; $display("FAIL clear_strobe got %b exp 00", {s1, s2}); end
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 1'($urandom), 2'($urandom), 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL clear_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL clear_u2 got %h exp %h", g2, exp2()); end
        end
        n_cmp++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL clear_word got %b exp 1", s1); end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1'($urandom), 2'($urandom), 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 2'b11, i % 2 == 0, i == 2);
            n_cmp++; if ({s1, s2} !== 2'b00) begin n_fail++; $display("FAIL enable_hold got %b exp 00", {s1, s2}); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 1'($urandom), 2'($urandom), 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL enable_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL enable_u2 got %h exp %h", g2, exp2()); end
        end
        n_cmp++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL enable_word got %b exp 1", s1); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 2'b10, 1, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (g1 !== '0) begin n_fail++; $display("FAIL reset_mid_u1 got %h exp 0", g1); end
        n_cmp++; if (g2 !== '0) begin n_fail++; $display("FAIL reset_mid_u2 got %h exp 0", g2); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1'($urandom), 1'($urandom), 2'($urandom), 1, 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL reset_mid_next_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL reset_mid_next_u2 got %h exp %h", g2, exp2()); end
        end
        n_cmp++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL reset_mid_word got %b exp 1", s1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7) != 0, $urandom_range(31) == 0, 1'($urandom), 1'($urandom), 2'($urandom),
                 $urandom_range(3) != 0, $urandom_range(7) == 0);
            n_cmp++; if (g1 !== exp1()) begin n_fail++; $display("FAIL random_u1 got %h exp %h", g1, exp1()); end
            n_cmp++; if (g2 !== exp2()) begin n_fail++; $display("FAIL random_u2 got %h exp %h", g2, exp2()); end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_byte();
        test_msb_chunks();
        test_flush();
        test_clear();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
